// File: rtl/gate_tt_sequencer_pkg.sv
// Shared types and widths for the gate truth-table sequencer family.
package gate_tt_sequencer_pkg;

  localparam int TT_WIDTH  = 4;
  localparam int IDX_WIDTH = 2;
  localparam int CNT_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/gate_tt_sequencer_if.sv
// Control/status bundle between a sweep requester (master) and the sequencer (slave).
interface gate_tt_sequencer_if;
  import gate_tt_sequencer_pkg::*;

  logic                start;
  logic                abort;
  logic [TT_WIDTH-1:0] exp_tt;
  logic                busy;
  logic                done;
  logic [TT_WIDTH-1:0] obs_tt;
  logic [TT_WIDTH-1:0] mismatch;
  logic                pass;

  modport master (
    output start, abort, exp_tt,
    input  busy, done, obs_tt, mismatch, pass
  );

  modport slave (
    input  start, abort, exp_tt,
    output busy, done, obs_tt, mismatch, pass
  );

endinterface

// File: rtl/settle_timer.sv
// Loadable settle down-counter; expire marks the last counting cycle.
module settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count,
  output logic             expire
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  // Terminal count at 1 so a load of N yields exactly N counting cycles.
  assign expire = count && (cnt == WIDTH'(1));

endmodule

// File: rtl/gate_tt_sequencer.sv
// Sweeps all four input vectors of an external 2-input gate and compares
// the sampled outputs against an expected truth table.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start; results from last sweep held
// ST_DRIVE  | drive vector idx onto gate_a/gate_b, load timer
// ST_WAIT   | let the gate settle for SETTLE_CYCLES cycles
// ST_SAMPLE | capture gate_y into obs_tt/mismatch at idx
// ST_DONE   | one-cycle done pulse, then back to idle
module gate_tt_sequencer
  import gate_tt_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
  input  logic                clk,
  input  logic                rst_n,
  gate_tt_sequencer_if.slave  ctl,
  output logic                gate_a,
  output logic                gate_b,
  input  logic                gate_y
);

  state_e               state;
  logic [IDX_WIDTH-1:0] idx;
  logic [TT_WIDTH-1:0]  exp_q;
  logic [TT_WIDTH-1:0]  obs_q;
  logic [TT_WIDTH-1:0]  mm_q;
  logic [TT_WIDTH-1:0]  mm_next;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic                 tmr_load;
  logic                 tmr_count;
  logic                 tmr_expire;

  assign tmr_load  = (state == ST_DRIVE);
  assign tmr_count = (state == ST_WAIT);

  settle_timer #(.WIDTH(CNT_WIDTH)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (CNT_WIDTH'(SETTLE_CYCLES)),
    .count    (tmr_count),
    .expire   (tmr_expire)
  );

  // Mismatch including the bit being sampled now, so pass lands with done.
  always_comb begin
    mm_next      = mm_q;
    mm_next[idx] = gate_y ^ exp_q[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      exp_q  <= '0;
      obs_q  <= '0;
      mm_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      gate_a <= 1'b0;
      gate_b <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ctl.abort && state != ST_IDLE) begin
        state  <= ST_IDLE;
        idx    <= '0;
        busy_q <= 1'b0;
        pass_q <= 1'b0;
        gate_a <= 1'b0;
        gate_b <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ctl.start && !ctl.abort) begin
              exp_q  <= ctl.exp_tt;
              obs_q  <= '0;
              mm_q   <= '0;
              pass_q <= 1'b0;
              idx    <= '0;
              busy_q <= 1'b1;
              state  <= ST_DRIVE;
            end
          end
          ST_DRIVE: begin
            {gate_a, gate_b} <= idx;
            state            <= ST_WAIT;
          end
          ST_WAIT: begin
            if (tmr_expire) state <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            obs_q[idx] <= gate_y;
            mm_q       <= mm_next;
            if (idx == IDX_WIDTH'(3)) begin
              done_q <= 1'b1;
              pass_q <= (mm_next == '0);
              state  <= ST_DONE;
            end else begin
              idx   <= idx + IDX_WIDTH'(1);
              state <= ST_DRIVE;
            end
          end
          ST_DONE: begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
          default: begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ctl.busy     = busy_q;
  assign ctl.done     = done_q;
  assign ctl.obs_tt   = obs_q;
  assign ctl.mismatch = mm_q;
  assign ctl.pass     = pass_q;

endmodule
